// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write/read port arbiters.
// Holds default geometry, the arbiter FSM state encoding and an NREG helper.
package regfile_pkg;

    localparam int unsigned REG_SELECT_WIDTH = 5;
    localparam int unsigned DATA_WIDTH       = 32;

    // Arbiter FSM states; kept as plain constants for legacy compatibility
    localparam logic INIT = 1'b0;
    localparam logic RUN  = 1'b1;

    // Number of registers addressed by a select of the given width
    function automatic int unsigned nregOf(input int unsigned selWidth);
        return 32'(1) << selWidth;
    endfunction

    localparam int unsigned NREG = nregOf(REG_SELECT_WIDTH);

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority select.
// Searches Req upward from Pointer (wrapping modulo NUM_REQ) and returns the
// first set bit as a one-hot Grant and a binary Winner.
// Ports:
//   Req      in   NUM_REQ     request vector
//   Pointer  in   PTR_WIDTH   highest-priority index this cycle
//   Grant    out  NUM_REQ     one-hot winner (0 when no request)
//   Winner   out  PTR_WIDTH   binary winner index (0 when no request)
//   AnyGrant out  1           at least one request present
module rr_priority_select #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PTR_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   Req,
    input  logic [PTR_WIDTH-1:0] Pointer,
    output logic [NUM_REQ-1:0]   Grant,
    output logic [PTR_WIDTH-1:0] Winner,
    output logic                 AnyGrant
);

    logic [PTR_WIDTH-1:0] idx;

    // First set bit at or after Pointer, wrapping
    always_comb begin
        Grant    = '0;
        Winner   = '0;
        AnyGrant = 1'b0;
        idx      = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = PTR_WIDTH'((int'(Pointer) + i) % int'(NUM_REQ));
            if (!AnyGrant && Req[idx]) begin
                AnyGrant   = 1'b1;
                Winner     = idx;
                Grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file's single write port.
// After reset it sweeps INIT_VALUE into every register, then shares the port
// round-robin among NUM_REQ requesters. Grant is combinational and consumes
// the request in the same cycle; the write appears on the registered outputs
// one cycle later.
// Build option: ZERO_REG_PROTECT_EN - in RUN, writes that target register 0
// are granted but their WriteEnable is suppressed.
// Ports:
//   Clk, Reset    clock and synchronous active-high reset
//   Req           per-requester write request (level)
//   ReqSelect     packed target registers, requester i at [i*RSW +: RSW]
//   ReqData       packed write data, requester i at [i*DW +: DW]
//   Stall         blocks all grants while high
//   Grant         combinational one-hot grant
//   WriteEnable   registered register-file write enable
//   WriteSelect   registered register-file write select
//   WriteData     registered register-file write data
//   InitDone      registered, high once the init sweep has completed
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned              REG_SELECT_WIDTH = regfile_pkg::REG_SELECT_WIDTH,
    parameter int unsigned              DATA_WIDTH       = regfile_pkg::DATA_WIDTH,
    parameter int unsigned              NUM_REQ          = 4,
    parameter logic [DATA_WIDTH-1:0]    INIT_VALUE       = '0
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [NUM_REQ-1:0]               Req,
    input  logic [NUM_REQ*REG_SELECT_WIDTH-1:0] ReqSelect,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    ReqData,
    input  logic                             Stall,
    output logic [NUM_REQ-1:0]               Grant,
    output logic                             WriteEnable,
    output logic [REG_SELECT_WIDTH-1:0]      WriteSelect,
    output logic [DATA_WIDTH-1:0]            WriteData,
    output logic                             InitDone
);

    localparam int unsigned PTR_WIDTH = $clog2(NUM_REQ);
    localparam int unsigned NREG_L    = nregOf(REG_SELECT_WIDTH);
    localparam logic [REG_SELECT_WIDTH-1:0] LAST_SEL = REG_SELECT_WIDTH'(NREG_L - 1);

    logic                        state, stateNext;
    logic [REG_SELECT_WIDTH-1:0] sweepCount, sweepCountNext;
    logic [PTR_WIDTH-1:0]        pointer, pointerNext;
    logic                        weNext;
    logic [REG_SELECT_WIDTH-1:0] selNext;
    logic [DATA_WIDTH-1:0]       dataNext;
    logic                        initDoneNext;

    logic [NUM_REQ-1:0]          rawGrant;
    logic [PTR_WIDTH-1:0]        winner;
    logic                        anyReq;
    logic                        grantOk;
    logic [REG_SELECT_WIDTH-1:0] winSel;
    logic [DATA_WIDTH-1:0]       winData;

    rr_priority_select #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (PTR_WIDTH)
    ) uSelect (
        .Req      (Req),
        .Pointer  (pointer),
        .Grant    (rawGrant),
        .Winner   (winner),
        .AnyGrant (anyReq)
    );

    // A grant only exists in RUN, outside reset, with no stall
    assign grantOk = (state == RUN) && !Stall && !Reset && anyReq;
    assign Grant   = grantOk ? rawGrant : '0;

    // Unpack the winning requester's select and data
    always_comb begin
        winSel  = '0;
        winData = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == PTR_WIDTH'(i)) begin
                winSel  = ReqSelect[i*REG_SELECT_WIDTH +: REG_SELECT_WIDTH];
                winData = ReqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State, counter, pointer and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= INIT;
            sweepCount  <= '0;
            pointer     <= '0;
            WriteEnable <= 1'b0;
            WriteSelect <= '0;
            WriteData   <= '0;
            InitDone    <= 1'b0;
        end else begin
            state       <= stateNext;
            sweepCount  <= sweepCountNext;
            pointer     <= pointerNext;
            WriteEnable <= weNext;
            WriteSelect <= selNext;
            WriteData   <= dataNext;
            InitDone    <= initDoneNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext      = state;
        sweepCountNext = sweepCount;
        pointerNext    = pointer;
        weNext         = 1'b0;
        selNext        = WriteSelect;
        dataNext       = WriteData;
        initDoneNext   = InitDone;

        case (state)
            INIT: begin
                weNext   = 1'b1;
                selNext  = sweepCount;
                dataNext = INIT_VALUE;
                // The counter parks on the last select instead of wrapping
                if (sweepCount == LAST_SEL) begin
                    stateNext    = RUN;
                    initDoneNext = 1'b1;
                end else begin
                    sweepCountNext = sweepCount + 1'b1;
                end
            end
            RUN: begin
                if (grantOk) begin
`ifdef ZERO_REG_PROTECT_EN
                    weNext = (winSel != '0);
`else
                    weNext = 1'b1;
`endif
                    selNext     = winSel;
                    dataNext    = winData;
                    pointerNext = (winner == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            default: stateNext = INIT;
        endcase
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default geometry:
// 32 registers, 32-bit data, 4 requesters, INIT_VALUE 0).
module tb_regfile_write_arbiter;

    localparam int unsigned RSW = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 4;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [NR-1:0]   Req;
    logic [NR*RSW-1:0] ReqSelect;
    logic [NR*DW-1:0]  ReqData;
    logic            Stall;
    logic [NR-1:0]   Grant;
    logic            WriteEnable;
    logic [RSW-1:0]  WriteSelect;
    logic [DW-1:0]   WriteData;
    logic            InitDone;

    int checks = 0;
    int errors = 0;

    // Register file fed by the arbiter outputs
    logic [DW-1:0] rf [32];
    always_ff @(posedge Clk) if (WriteEnable) rf[WriteSelect] <= WriteData;

    regfile_write_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req         (Req),
        .ReqSelect   (ReqSelect),
        .ReqData     (ReqData),
        .Stall       (Stall),
        .Grant       (Grant),
        .WriteEnable (WriteEnable),
        .WriteSelect (WriteSelect),
        .WriteData   (WriteData),
        .InitDone    (InitDone)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [RSW-1:0] sel, input logic [DW-1:0] data);
        ReqSelect[i*RSW +: RSW] = sel;
        ReqData[i*DW +: DW]     = data;
    endtask

    // n sweep cycles starting at select 0, Req all high to prove no grants
    task automatic runSweep(input int n, input string tag);
        Req = 4'b1111;
        for (int k = 0; k < n; k++) begin
            #1 checkVal({tag, " grant"}, 64'(Grant), 64'h0);
            tick();
            checkVal({tag, " we"}, 64'(WriteEnable), 64'h1);
            checkVal({tag, " sel"}, 64'(WriteSelect), 64'(k));
            checkVal({tag, " data"}, 64'(WriteData), 64'h0);
            checkVal({tag, " initdone"}, 64'(InitDone), 64'(k == 31));
        end
    endtask

    // Drive Req, check the combinational grant, then the registered write
    task automatic grantStep(input string tag, input logic [NR-1:0] r, input logic [NR-1:0] expGrant,
                             input logic expWe, input logic [RSW-1:0] expSel, input logic [DW-1:0] expData);
        Req = r;
        #1 checkVal({tag, " grant"}, 64'(Grant), 64'(expGrant));
        tick();
        checkVal({tag, " we"}, 64'(WriteEnable), 64'(expWe));
        checkVal({tag, " sel"}, 64'(WriteSelect), 64'(expSel));
        checkVal({tag, " data"}, 64'(WriteData), 64'(expData));
    endtask

    logic [RSW-1:0] sels [NR];
    logic [DW-1:0]  datas [NR];
    logic           zeroWe;

    initial begin
        Reset = 1'b1; Req = 4'b1111; Stall = 1'b0; ReqSelect = '0; ReqData = '0;
        #1 checkVal("reset grant", 64'(Grant), 64'h0);
        tick();
        checkVal("reset we", 64'(WriteEnable), 64'h0);
        checkVal("reset sel", 64'(WriteSelect), 64'h0);
        checkVal("reset data", 64'(WriteData), 64'h0);
        checkVal("reset initdone", 64'(InitDone), 64'h0);
        Reset = 1'b0;
        Stall = 1'b1;
        runSweep(32, "sweep");
        Stall = 1'b0;

        // Full contention: 0,1,2,3,0,1,2,3
        for (int i = 0; i < int'(NR); i++) begin
            sels[i]  = RSW'(3 * i + 1);
            datas[i] = 32'hA000_0000 + DW'(i);
            setReq(i, sels[i], datas[i]);
        end
        for (int c = 0; c < 8; c++)
            grantStep("rr", 4'b1111, 4'(1 << (c % 4)), 1'b1, sels[c % 4], datas[c % 4]);

        // Move pointer to 1, then alternate between requesters 2 and 0
        grantStep("ptr1", 4'b0001, 4'b0001, 1'b1, sels[0], datas[0]);
        setReq(2, 5'd9, 32'hDEADBEEF);
        grantStep("alt a", 4'b0101, 4'b0100, 1'b1, 5'd9, 32'hDEADBEEF);
        grantStep("alt b", 4'b0101, 4'b0001, 1'b1, sels[0], datas[0]);
        grantStep("alt c", 4'b0101, 4'b0100, 1'b1, 5'd9, 32'hDEADBEEF);

        // Idle: write enable drops, select/data hold
        grantStep("idle", 4'b0000, 4'b0000, 1'b0, 5'd9, 32'hDEADBEEF);

        // Stall with pointer at 3
        Stall = 1'b1;
        for (int c = 0; c < 3; c++)
            grantStep("stall", 4'b0010, 4'b0000, 1'b0, 5'd9, 32'hDEADBEEF);
        Stall = 1'b0;
        grantStep("unstall", 4'b0010, 4'b0010, 1'b1, sels[1], datas[1]);
        // Pointer now 2: requester 3 beats 0 and 1
        grantStep("ptr2", 4'b1011, 4'b1000, 1'b1, sels[3], datas[3]);

        // Register 0 write from requester 0 (pointer now 0)
`ifdef ZERO_REG_PROTECT_EN
        zeroWe = 1'b0;
`else
        zeroWe = 1'b1;
`endif
        setReq(0, 5'd0, 32'h1);
        grantStep("zero", 4'b0001, 4'b0001, zeroWe, 5'd0, 32'h1);
        grantStep("after zero", 4'b0011, 4'b0010, 1'b1, sels[1], datas[1]);
        checkVal("rf0", 64'(rf[0]), zeroWe ? 64'h1 : 64'h0);
        checkVal("rf9", 64'(rf[9]), 64'hDEADBEEF);

        // Reset during RUN
        Req = 4'b1111;
        Reset = 1'b1;
        #1 checkVal("run reset grant", 64'(Grant), 64'h0);
        tick();
        checkVal("run reset we", 64'(WriteEnable), 64'h0);
        checkVal("run reset initdone", 64'(InitDone), 64'h0);
        Reset = 1'b0;

        // Reset at sweep count 10, then a complete sweep
        runSweep(10, "part");
        Reset = 1'b1;
        tick();
        checkVal("mid reset we", 64'(WriteEnable), 64'h0);
        checkVal("mid reset sel", 64'(WriteSelect), 64'h0);
        Reset = 1'b0;
        runSweep(32, "resweep");
        checkVal("rf0 cleared", 64'(rf[0]), 64'h0);
        tick();
        checkVal("rf31 cleared", 64'(rf[31]), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
